// File: rtl/drive_arbiter.sv
// Round-robin owner arbiter for a shared wired net, with IDLE/GRANT/TURN sequencing and a dead turnaround gap.
// Latency: grant registered one edge after selection; release drops gnt the edge after req low or done.
// Backpressure: non-owners wait while held, no queueing. Define DRIVE_ARB_TIMEOUT_EN to force release after HOLD_MAX grant cycles.
module drive_arbiter #(
    parameter int N_REQ    = 4,
    parameter int HOLD_MAX = 8,
    parameter int TURN_CYC = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         done,
    output logic [N_REQ-1:0]         gnt,
    output logic                     drive_en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_idle,
    output logic                     timeout_pulse
);

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || HOLD_MAX < 1 || HOLD_MAX > 255 ||
        TURN_CYC < 1 || TURN_CYC > 3) begin : g_bad_param
        $error("drive_arbiter: parameter out of legal range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [N_REQ-1:0] gnt_nxt;
    logic [IW-1:0]    owner_nxt;
    logic [IW-1:0]    rr_ptr, rr_nxt;
    logic [1:0]       turn_cnt, turn_nxt;
    logic             grant_start;
    logic             release_go;
    logic             hold_expired;

    logic [IW-1:0]    pick;
    logic             pick_found;
    logic [IW:0]      scan_sum;
    logic [IW-1:0]    scan_idx;

    // First requester at or above rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        scan_sum   = '0;
        scan_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr} + (IW+1)'(i);
            if (scan_sum >= (IW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IW+1)'(N_REQ);
            end
            scan_idx = scan_sum[IW-1:0];
            if (!pick_found && req[scan_idx]) begin
                pick_found = 1'b1;
                pick       = scan_idx;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        owner_nxt   = owner;
        rr_nxt      = rr_ptr;
        turn_nxt    = turn_cnt;
        grant_start = 1'b0;
        release_go  = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) grant_start = 1'b1;
            end
            GRANT: begin
                if (!req[owner] || done[owner] || hold_expired) release_go = 1'b1;
            end
            TURN: begin
                if (turn_cnt == 2'(TURN_CYC - 1)) begin
                    if (pick_found) grant_start = 1'b1;
                    else            state_nxt   = IDLE;
                end else begin
                    turn_nxt = turn_cnt + 2'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (grant_start) begin
            state_nxt       = GRANT;
            gnt_nxt         = '0;
            gnt_nxt[pick]   = 1'b1;
            owner_nxt       = pick;
        end
        if (release_go) begin
            state_nxt = TURN;
            gnt_nxt   = '0;
            turn_nxt  = '0;
            rr_nxt    = (owner == IW'(N_REQ - 1)) ? '0 : owner + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            gnt      <= '0;
            drive_en <= 1'b0;
            owner    <= '0;
            rr_ptr   <= '0;
            turn_cnt <= '0;
        end else begin
            state    <= state_nxt;
            gnt      <= gnt_nxt;
            drive_en <= |gnt_nxt;
            owner    <= owner_nxt;
            rr_ptr   <= rr_nxt;
            turn_cnt <= turn_nxt;
        end
    end

    assign bus_idle = (state == IDLE);

`ifdef DRIVE_ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;

    // hold_cnt holds the 1-based index of the current grant cycle.
    assign hold_expired = (state == GRANT) && (hold_cnt == 8'(HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt      <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= release_go && hold_expired && req[owner] && !done[owner];
            if (grant_start)          hold_cnt <= 8'd1;
            else if (release_go)      hold_cnt <= '0;
            else if (state == GRANT)  hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    assign hold_expired  = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter (N_REQ=4, HOLD_MAX=8, TURN_CYC=1); honours DRIVE_ARB_TIMEOUT_EN.
module tb_drive_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] done = '0;
    logic [3:0] gnt;
    logic       drive_en;
    logic [1:0] owner;
    logic       bus_idle;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    drive_arbiter #(
        .N_REQ    (4),
        .HOLD_MAX (8),
        .TURN_CYC (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .drive_en      (drive_en),
        .owner         (owner),
        .bus_idle      (bus_idle),
        .timeout_pulse (timeout_pulse)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        done  = '0;
        #1;
        chk("rst_gnt",   32'(gnt), 32'h0);
        chk("rst_den",   32'(drive_en), 32'h0);
        chk("rst_owner", 32'(owner), 32'h0);
        chk("rst_idle",  32'(bus_idle), 32'h1);
        chk("rst_tmo",   32'(timeout_pulse), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // Invariants on the shared net, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("onehot0_gnt", 32'($onehot0(gnt)), 32'h1);
            chk("den_eq_or_gnt", 32'(drive_en), 32'(|gnt));
            if (bus_idle) chk("idle_gnt_zero", 32'(gnt), 32'h0);
        end
    end

    initial begin
        logic [3:0] rr_exp [5];
        logic [3:0] exp_g;
        logic       exp_t;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

        // Single request held for five grant cycles.
        do_reset();
        req = 4'b0001;
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("single_gnt", 32'(gnt), 32'h1);
            chk("single_den", 32'(drive_en), 32'h1);
            if (c == 5) req = 4'b0000;
        end
        tick();
        chk("single_turn_gnt",  32'(gnt), 32'h0);
        chk("single_turn_idle", 32'(bus_idle), 32'h0);
        tick();
        chk("single_idle",  32'(bus_idle), 32'h1);
        chk("single_owner", 32'(owner), 32'h0);

        // Round robin with all requesters active, done after two grant cycles.
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rr_gnt_c1", 32'(gnt), 32'(rr_exp[i]));
            tick();
            chk("rr_gnt_c2", 32'(gnt), 32'(rr_exp[i]));
            done = rr_exp[i];
            tick();
            done = '0;
            chk("rr_turn_gnt", 32'(gnt), 32'h0);
        end
        req = '0;
        tick();
        tick();

        // Long hold by requester 2.
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 19; c++) begin
            tick();
`ifdef DRIVE_ARB_TIMEOUT_EN
            exp_t = (((c - 1) % 9) == 8);
            exp_g = exp_t ? 4'b0000 : 4'b0100;
`else
            exp_t = 1'b0;
            exp_g = 4'b0100;
`endif
            chk("hold_gnt", 32'(gnt), 32'(exp_g));
            chk("hold_tmo", 32'(timeout_pulse), 32'(exp_t));
        end
        req = '0;
        tick();
        tick();
        tick();

        // Reset mid-grant with rr_ptr advanced to 2 beforehand.
        do_reset();
        req = 4'b0010;
        tick();
        chk("mrst_first_gnt", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        chk("mrst_regrant", 32'(gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_async_gnt",  32'(gnt), 32'h0);
        chk("mrst_async_den",  32'(drive_en), 32'h0);
        chk("mrst_async_idle", 32'(bus_idle), 32'h1);
        req = 4'b1010;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("mrst_after_gnt",   32'(gnt), 32'h2);
        chk("mrst_after_owner", 32'(owner), 32'h1);

        // Owner release coinciding with a new request, then wrap from rr_ptr=3.
        do_reset();
        req = 4'b0010;
        tick();
        chk("sim_gnt1", 32'(gnt), 32'h2);
        req = 4'b0100;
        tick();
        chk("sim_turn", 32'(gnt), 32'h0);
        tick();
        chk("sim_gnt2",  32'(gnt), 32'h4);
        chk("sim_owner", 32'(owner), 32'h2);
        done = 4'b0001;
        tick();
        chk("nonowner_done", 32'(gnt), 32'h4);
        done = '0;
        req  = 4'b0011;
        tick();
        chk("wrap_turn",       32'(gnt), 32'h0);
        chk("wrap_turn_owner", 32'(owner), 32'h2);
        tick();
        chk("wrap_gnt",   32'(gnt), 32'h1);
        chk("wrap_owner", 32'(owner), 32'h0);
        req = '0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
